// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified-memory port arbiter.
package mem_arb_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   // The memory is word organised; byte offset bits are simply dropped.
   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
      return a & ~ADDR_W'(3);
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision between fetch and data, with the fetch-starvation counter.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   ireq,
   input  logic   dreq,
   input  logic   grant_en,
   output owner_e grant_owner
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt_q;
   logic [3:0] starve_cnt_d;

   // Data normally wins; once fetch has waited out LIMIT data grants it goes first.
   always_comb begin
      grant_owner = OWN_I;
      if (dreq && !(ireq && (starve_cnt_q == LIMIT))) begin
         grant_owner = OWN_D;
      end
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (grant_en) begin
         if ((grant_owner == OWN_D) && ireq) begin
            if (starve_cnt_q != LIMIT) begin
               starve_cnt_d = starve_cnt_q + 4'd1;
            end
         end else begin
            starve_cnt_d = 4'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt_q <= 4'd0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and MEM-stage data requesters.
// Optional per-requester stall counters are enabled with MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WAIT_CYCLES  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ireq,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iack,
   output logic [DATA_W-1:0] irdata,
   input  logic              dreq,
   input  logic              dwe,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dwdata,
   input  logic [BE_W-1:0]   dbe,
   output logic              dack,
   output logic [DATA_W-1:0] drdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [BE_W-1:0]   mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_ARB_PERF_CNT_EN
   output logic [31:0]       istall_cnt,
   output logic [31:0]       dstall_cnt,
`endif
   output logic              busy
);

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   arb_state_e        state_q,  state_d;
   owner_e            owner_q,  owner_d;
   logic [ADDR_W-1:0] addr_q,   addr_d;
   logic [DATA_W-1:0] wdata_q,  wdata_d;
   logic [BE_W-1:0]   be_q,     be_d;
   logic              we_q,     we_d;
   logic [3:0]        wait_q,   wait_d;
   logic [DATA_W-1:0] rsp_q,    rsp_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic              iack_q,   iack_d;
   logic              dack_q,   dack_d;
   logic              busy_q,   busy_d;

   owner_e grant_owner;
   logic   grant_en;

   assign grant_en = (state_q == IDLE) && (ireq || dreq);

   mem_arb_pick #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_pick (
      .clk         (clk),
      .reset       (reset),
      .ireq        (ireq),
      .dreq        (dreq),
      .grant_en    (grant_en),
      .grant_owner (grant_owner)
   );

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      we_d     = we_q;
      wait_d   = wait_q;
      rsp_d    = rsp_q;
      mem_en_d = mem_en_q;
      mem_we_d = mem_we_q;
      iack_d   = 1'b0;
      dack_d   = 1'b0;
      busy_d   = busy_q;
      unique case (state_q)
         IDLE: begin
            if (grant_en) begin
               state_d  = ACCESS;
               owner_d  = grant_owner;
               wait_d   = WAIT_INIT;
               mem_en_d = 1'b1;
               busy_d   = 1'b1;
               if (grant_owner == OWN_D) begin
                  addr_d   = word_addr(daddr);
                  wdata_d  = dwdata;
                  be_d     = dbe;
                  we_d     = dwe;
                  mem_we_d = dwe;
               end else begin
                  addr_d   = word_addr(iaddr);
                  wdata_d  = '0;
                  be_d     = '1;
                  we_d     = 1'b0;
                  mem_we_d = 1'b0;
               end
            end
         end
         ACCESS: begin
            if (wait_q != 4'd0) begin
               wait_d = wait_q - 4'd1;
            end else begin
               // Writes leave the response register untouched so drdata stays stable.
               if (!we_q) begin
                  rsp_d = mem_rdata;
               end
               state_d  = RESP;
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
               iack_d   = (owner_q == OWN_I);
               dack_d   = (owner_q == OWN_D);
            end
         end
         RESP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d  = IDLE;
            mem_en_d = 1'b0;
            mem_we_d = 1'b0;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         owner_q  <= OWN_I;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         we_q     <= 1'b0;
         wait_q   <= 4'd0;
         rsp_q    <= '0;
         mem_en_q <= 1'b0;
         mem_we_q <= 1'b0;
         iack_q   <= 1'b0;
         dack_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         we_q     <= we_d;
         wait_q   <= wait_d;
         rsp_q    <= rsp_d;
         mem_en_q <= mem_en_d;
         mem_we_q <= mem_we_d;
         iack_q   <= iack_d;
         dack_q   <= dack_d;
         busy_q   <= busy_d;
      end
   end

   assign iack      = iack_q;
   assign dack      = dack_q;
   assign irdata    = rsp_q;
   assign drdata    = rsp_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = be_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = busy_q;

`ifdef MEM_ARB_PERF_CNT_EN
   logic [31:0] istall_q, istall_d;
   logic [31:0] dstall_q, dstall_d;

   // A requester is stalled in every cycle it is asking and not being acked.
   always_comb begin
      istall_d = istall_q;
      dstall_d = dstall_q;
      if (ireq && !iack_q) begin
         istall_d = istall_q + 32'd1;
      end
      if (dreq && !dack_q) begin
         dstall_d = dstall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         istall_q <= '0;
         dstall_q <= '0;
      end else begin
         istall_q <= istall_d;
         dstall_q <= dstall_d;
      end
   end

   assign istall_cnt = istall_q;
   assign dstall_cnt = dstall_q;
`else
   // Without the counters the port list carries no stall outputs.
`endif

endmodule
